// File: rtl/fft_peak_detect_if.sv
// Magnitude-in / peak-report-out bundle for fft_peak_detect; the producer side is master.
interface fft_peak_detect_if #(
    parameter int W     = 16,
    parameter int NBINS = 1024,
    parameter int IDX_W = $clog2(NBINS)
);
    logic               mag_valid;
    logic [2*W:0]       mag_sq;
    logic               frame_rst;
    logic [2*W:0]       threshold;
    logic               peak_valid;
    logic [IDX_W-1:0]   peak_bin;
    logic [2*W:0]       peak_mag;
    logic               peak_found;
    logic [15:0]        frame_cnt;

    modport master (
        output mag_valid, mag_sq, frame_rst, threshold,
        input  peak_valid, peak_bin, peak_mag, peak_found, frame_cnt
    );

    modport slave (
        input  mag_valid, mag_sq, frame_rst, threshold,
        output peak_valid, peak_bin, peak_mag, peak_found, frame_cnt
    );
endinterface

// File: rtl/fft_peak_detect.sv
// Per-frame max search on |X|^2; report 1 cycle after the last bin, no backpressure (one bin per mag_valid).
// FFT_PEAK_IGNORE_DC_EN: when defined, bin 0 is never a peak candidate.
module fft_peak_detect #(
    parameter int W             = 16,
    parameter int NBINS         = 1024,
    parameter int IDX_W         = $clog2(NBINS),
    parameter int HALF_SPECTRUM = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    fft_peak_detect_if.slave   bus
);
    localparam int MW = 2*W+1;
    localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(NBINS-1);

    logic [IDX_W-1:0] bin_cnt_q;
    logic [MW-1:0]    best_mag_q;
    logic [IDX_W-1:0] best_bin_q;
    logic             have_best_q;
    logic             peak_valid_q;
    logic [IDX_W-1:0] peak_bin_q;
    logic [MW-1:0]    peak_mag_q;
    logic             peak_found_q;
    logic [15:0]      frame_cnt_q;

    logic             hi_ok, dc_ok, cand_vld, take, frame_end, best_have_d;
    logic [MW-1:0]    best_mag_d;
    logic [IDX_W-1:0] best_bin_d;

    // NBINS is a power of two, so the upper half is exactly the bins with the MSB set.
    assign hi_ok = (HALF_SPECTRUM != 0) ? ~bin_cnt_q[IDX_W-1] : 1'b1;
`ifdef FFT_PEAK_IGNORE_DC_EN
    assign dc_ok = (bin_cnt_q != '0);
`else
    assign dc_ok = 1'b1;
`endif

    assign cand_vld    = bus.mag_valid & ~bus.frame_rst & hi_ok & dc_ok;
    assign take        = cand_vld & (~have_best_q | (bus.mag_sq > best_mag_q));
    assign best_mag_d  = take ? bus.mag_sq : best_mag_q;
    assign best_bin_d  = take ? bin_cnt_q  : best_bin_q;
    assign best_have_d = have_best_q | cand_vld;
    assign frame_end   = bus.mag_valid & ~bus.frame_rst & (bin_cnt_q == LAST_BIN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin_cnt_q    <= '0;
            best_mag_q   <= '0;
            best_bin_q   <= '0;
            have_best_q  <= 1'b0;
            peak_valid_q <= 1'b0;
            peak_bin_q   <= '0;
            peak_mag_q   <= '0;
            peak_found_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            peak_valid_q <= frame_end;
            if (bus.frame_rst) begin
                bin_cnt_q   <= '0;
                have_best_q <= 1'b0;
                best_mag_q  <= '0;
                best_bin_q  <= '0;
            end else if (bus.mag_valid) begin
                bin_cnt_q <= bin_cnt_q + IDX_W'(1);
                if (frame_end) begin
                    // Report includes this final beat; running state restarts for the next frame.
                    peak_bin_q   <= best_have_d ? best_bin_d : '0;
                    peak_mag_q   <= best_have_d ? best_mag_d : '0;
                    peak_found_q <= best_have_d & (best_mag_d > bus.threshold);
                    frame_cnt_q  <= frame_cnt_q + 16'd1;
                    have_best_q  <= 1'b0;
                    best_mag_q   <= '0;
                    best_bin_q   <= '0;
                end else begin
                    have_best_q <= best_have_d;
                    best_mag_q  <= best_mag_d;
                    best_bin_q  <= best_bin_d;
                end
            end
        end
    end

    assign bus.peak_valid = peak_valid_q;
    assign bus.peak_bin   = peak_bin_q;
    assign bus.peak_mag   = peak_mag_q;
    assign bus.peak_found = peak_found_q;
    assign bus.frame_cnt  = frame_cnt_q;
endmodule

// File: tb/tb_fft_peak_detect.sv
// Drives one sample stream into a full-spectrum and a half-spectrum instance (NBINS=8) and checks both
// against a frame-buffer argmax model; directed frames pin the model to hand-computed values.
module tb_fft_peak_detect;
    localparam int W     = 16;
    localparam int NBINS = 8;
    localparam int IDX_W = 3;
    localparam int MW    = 2*W+1;
`ifdef FFT_PEAK_IGNORE_DC_EN
    localparam int LO = 1;
`else
    localparam int LO = 0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          mag_valid = 1'b0;
    logic [MW-1:0] mag_sq = '0;
    logic          frame_rst = 1'b0;
    logic [MW-1:0] threshold = '0;

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    fft_peak_detect_if #(.W(W), .NBINS(NBINS)) bf ();
    fft_peak_detect_if #(.W(W), .NBINS(NBINS)) bh ();

    assign bf.mag_valid = mag_valid;
    assign bf.mag_sq    = mag_sq;
    assign bf.frame_rst = frame_rst;
    assign bf.threshold = threshold;
    assign bh.mag_valid = mag_valid;
    assign bh.mag_sq    = mag_sq;
    assign bh.frame_rst = frame_rst;
    assign bh.threshold = threshold;

    fft_peak_detect #(.W(W), .NBINS(NBINS), .HALF_SPECTRUM(0)) u_full (
        .clk(clk), .reset_n(reset_n), .bus(bf.slave));
    fft_peak_detect #(.W(W), .NBINS(NBINS), .HALF_SPECTRUM(1)) u_half (
        .clk(clk), .reset_n(reset_n), .bus(bh.slave));

    // Model: buffer the frame, take the lowest-index maximum over the search range at frame end.
    logic [MW-1:0]    fbuf [NBINS];
    int               cnt;
    logic             exp_valid;
    logic [15:0]      exp_frames;
    logic [IDX_W-1:0] exp_bin   [2];
    logic [MW-1:0]    exp_mag   [2];
    logic             exp_found [2];
    int               hi, best;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt = 0;
            exp_valid = 1'b0;
            exp_frames = '0;
            for (int d = 0; d < 2; d++) begin
                exp_bin[d] = '0; exp_mag[d] = '0; exp_found[d] = 1'b0;
            end
        end else begin
            exp_valid = 1'b0;
            if (frame_rst) begin
                cnt = 0;
            end else if (mag_valid) begin
                fbuf[cnt] = mag_sq;
                if (cnt == NBINS-1) begin
                    for (int d = 0; d < 2; d++) begin
                        hi = (d == 0) ? NBINS : NBINS/2;
                        best = -1;
                        for (int b = LO; b < hi; b++)
                            if (best < 0 || fbuf[b] > fbuf[best]) best = b;
                        exp_bin[d]   = (best < 0) ? '0 : IDX_W'(best);
                        exp_mag[d]   = (best < 0) ? '0 : fbuf[best];
                        exp_found[d] = (best >= 0) && (fbuf[best] > threshold);
                    end
                    exp_valid = 1'b1;
                    exp_frames = exp_frames + 16'd1;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("full.peak_valid", 64'(bf.peak_valid), 64'(exp_valid));
            chk("full.peak_bin",   64'(bf.peak_bin),   64'(exp_bin[0]));
            chk("full.peak_mag",   64'(bf.peak_mag),   64'(exp_mag[0]));
            chk("full.peak_found", 64'(bf.peak_found), 64'(exp_found[0]));
            chk("full.frame_cnt",  64'(bf.frame_cnt),  64'(exp_frames));
            chk("half.peak_valid", 64'(bh.peak_valid), 64'(exp_valid));
            chk("half.peak_bin",   64'(bh.peak_bin),   64'(exp_bin[1]));
            chk("half.peak_mag",   64'(bh.peak_mag),   64'(exp_mag[1]));
            chk("half.peak_found", 64'(bh.peak_found), 64'(exp_found[1]));
            chk("half.frame_cnt",  64'(bh.frame_cnt),  64'(exp_frames));
        end
    end

    task automatic beat(input logic v, input logic [MW-1:0] m, input logic fr);
        @(negedge clk);
        #1;
        mag_valid = v; mag_sq = m; frame_rst = fr;
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input int vals [NBINS], input int gap);
        for (int i = 0; i < NBINS; i++) begin
            beat(1'b1, MW'(vals[i]), 1'b0);
            if (i != NBINS-1)
                for (int g = 0; g < gap; g++) beat(1'b0, '0, 1'b0);
        end
    endtask

    // Literal pin on both the model and the DUT.
    task automatic pin(input string nm, input int d, input int pv, input int bn, input int mg, input int fd);
        chk({nm, ".model_valid"}, 64'(exp_valid), 64'(pv));
        chk({nm, ".model_bin"},   64'(exp_bin[d]), 64'(bn));
        chk({nm, ".model_mag"},   64'(exp_mag[d]), 64'(mg));
        chk({nm, ".model_found"}, 64'(exp_found[d]), 64'(fd));
        chk({nm, ".dut_valid"}, 64'(d == 0 ? bf.peak_valid : bh.peak_valid), 64'(pv));
        chk({nm, ".dut_bin"},   64'(d == 0 ? bf.peak_bin   : bh.peak_bin),   64'(bn));
        chk({nm, ".dut_mag"},   64'(d == 0 ? bf.peak_mag   : bh.peak_mag),   64'(mg));
        chk({nm, ".dut_found"}, 64'(d == 0 ? bf.peak_found : bh.peak_found), 64'(fd));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        mag_valid = 1'b0; frame_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.frame_cnt", 64'(bf.frame_cnt), 64'd0);
        chk("rst.peak_mag",  64'(bf.peak_mag),  64'd0);
        chk("rst.peak_bin",  64'(bh.peak_bin),  64'd0);
        chk("rst.peak_found",64'(bf.peak_found),64'd0);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    int fa [NBINS] = '{8, 3, 50, 7, 50, 1, 2, 9};
    int fb [NBINS] = '{1, 2, 3, 4, 99, 99, 99, 99};
    int fc [NBINS] = '{0, 0, 0, 0, 0, 0, 0, 5};
    int fd [NBINS] = '{1, 2, 3, 4, 5, 6, 7, 8};
    int fe [NBINS] = '{100, 1, 2, 3, 4, 5, 6, 7};

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("init.peak_valid", 64'(bf.peak_valid), 64'd0);
        chk("init.frame_cnt",  64'(bh.frame_cnt),  64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        chk_en = 1'b1;

        threshold = MW'(40);
        frame(fa, 0);
        pin("tie_full", 0, 1, 2, 50, 1);
        pin("tie_half", 1, 1, 2, 50, 1);
        chk("tie.frame_cnt", 64'(bf.frame_cnt), 64'd1);

        threshold = MW'(10);
        frame(fb, 0);
        pin("half_half", 1, 1, 3, 4, 0);
        pin("half_full", 0, 1, 4, 99, 1);

        frame(fc, 2);
        pin("gap_full", 0, 1, 7, 5, 0);
        beat(1'b0, '0, 1'b0);
        chk("gap.pulse_width", 64'(bf.peak_valid), 64'd0);

        // Mid-frame async reset, then a frame aborted by frame_rst carrying a sample.
        for (int i = 0; i < 3; i++) beat(1'b1, MW'(77), 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) beat(1'b1, MW'(9), 1'b0);
        beat(1'b1, MW'(200), 1'b1);
        frame(fd, 0);
        pin("frst_full", 0, 1, 7, 8, 0);
        pin("frst_half", 1, 1, 3, 4, 0);
        chk("frst.frame_cnt", 64'(bf.frame_cnt), 64'd1);

        frame(fe, 0);
`ifdef FFT_PEAK_IGNORE_DC_EN
        pin("dc_full", 0, 1, 7, 7, 0);
        pin("dc_half", 1, 1, 3, 3, 0);
`else
        pin("dc_full", 0, 1, 0, 100, 1);
        pin("dc_half", 1, 1, 0, 100, 1);
`endif

        for (int n = 0; n < 1500; n++) begin
            logic [MW-1:0] m;
            case ($urandom_range(0, 3))
                0: m = MW'($urandom_range(0, 15));
                1: m = {1'($urandom_range(0, 1)), 32'($urandom)};
                2: m = '1;
                default: m = MW'($urandom_range(0, 255));
            endcase
            if ($urandom_range(0, 7) == 0)
                threshold = ($urandom_range(0, 1) != 0) ? MW'($urandom_range(0, 15))
                                                         : {1'($urandom_range(0, 1)), 32'($urandom)};
            if (n == 777) do_reset();
            beat($urandom_range(0, 9) < 7, m, $urandom_range(0, 49) == 0);
        end

        beat(1'b0, '0, 1'b0);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
